// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU serial receive path: word width default,
// frame FSM encoding and a small saturating-counter helper.
package pmu_pkg;

    localparam int unsigned PMU_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } pmu_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pmu_word_fifo.sv
// First-word-fall-through word FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge, otherwise it is reported as dropped.
module pmu_word_fifo #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              tck_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              ready_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    output logic              accept_o,
    output logic              drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic              empty;
    logic              full;
    logic              pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop      = !empty && ready_i;
    assign accept_o = push_i && (!full || pop);
    assign drop_o   = push_i && full && !pop;
    assign valid_o  = !empty;
    // Gated so the head reads as zero while empty, including straight out of reset.
    assign data_o   = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (accept_o) wr_q <= wr_q + (AW+1)'(1);
            if (pop)      rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge tck_i) begin
        if (accept_o) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/pmu_stream_rx.sv
// Deserialises a TAP data-register stream into words, optionally checking a
// trailing two's-complement checksum word, and queues the data words.
module pmu_stream_rx
    import pmu_pkg::*;
#(
    parameter int unsigned WORD_W     = PMU_WORD_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              tck_i,
    input  logic              rst_ni,
    input  logic              capture_i,
    input  logic              shift_i,
    input  logic              update_i,
    input  logic              td_i,
    input  logic              checksum_en_i,
    output logic              td_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic [15:0]       word_count_o,
    output logic              done_o,
    output logic              cs_ok_o,
    output logic              cs_err_o,
    output logic              frame_err_o,
    output logic              overflow_o
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    pmu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic [WORD_W-1:0] push_data_q, push_data_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [15:0]       count_q, count_d;
    logic              cs_mode_q, cs_mode_d;
    logic              pend_v_q, pend_v_d;
    logic              push_v_q, push_v_d;
    logic              done_q, done_d;
    logic              cs_ok_q, cs_ok_d;
    logic              cs_err_q, cs_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              td_q, td_d;

    logic              push_accept;
    logic              push_drop;
    logic [WORD_W-1:0] sum_eff;
    logic [WORD_W-1:0] shift_nxt;

    pmu_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .tck_i       (tck_i),
        .rst_ni      (rst_ni),
        .push_i      (push_v_q),
        .push_data_i (push_data_q),
        .ready_i     (word_ready_i),
        .data_o      (word_o),
        .valid_o     (word_valid_o),
        .accept_o    (push_accept),
        .drop_o      (push_drop)
    );

    // The sum seen by an update includes a push that lands on that same edge.
    assign sum_eff   = sum_q + (push_accept ? push_data_q : '0);
    assign shift_nxt = {td_i, shift_q[WORD_W-1:1]};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        push_v_d    = 1'b0;
        push_data_d = push_data_q;
        sum_d       = sum_q;
        count_d     = count_q;
        cs_mode_d   = cs_mode_q;
        done_d      = done_q;
        cs_ok_d     = cs_ok_q;
        cs_err_d    = cs_err_q;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        td_d        = td_q;

        if (push_accept) begin
            sum_d   = sum_eff;
            count_d = sat_inc16(count_q);
        end
        if (push_drop) overflow_d = 1'b1;

        if (capture_i) begin
            state_d     = ST_SHIFT;
            bit_cnt_d   = '0;
            pend_v_d    = 1'b0;
            sum_d       = '0;
            count_d     = '0;
            cs_mode_d   = checksum_en_i;
            done_d      = 1'b0;
            cs_ok_d     = 1'b0;
            cs_err_d    = 1'b0;
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (update_i) begin
                state_d     = ST_DONE;
                done_d      = 1'b1;
                frame_err_d = (bit_cnt_q != '0);
                pend_v_d    = 1'b0;
                if (cs_mode_q) begin
                    cs_ok_d  = pend_v_q && (pend_q == (~sum_eff + WORD_W'(1)));
                    cs_err_d = !(pend_v_q && (pend_q == (~sum_eff + WORD_W'(1))));
                end
            end else if (shift_i) begin
                shift_d = shift_nxt;
                td_d    = shift_nxt[0];
                if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                    bit_cnt_d = '0;
                    if (cs_mode_q) begin
                        // Hold back each word: only the final one is the checksum.
                        pend_d   = shift_nxt;
                        pend_v_d = 1'b1;
                        if (pend_v_q) begin
                            push_v_d    = 1'b1;
                            push_data_d = pend_q;
                        end
                    end else begin
                        push_v_d    = 1'b1;
                        push_data_d = shift_nxt;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            push_v_q    <= 1'b0;
            push_data_q <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            cs_mode_q   <= 1'b0;
            done_q      <= 1'b0;
            cs_ok_q     <= 1'b0;
            cs_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            td_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            push_v_q    <= push_v_d;
            push_data_q <= push_data_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            cs_mode_q   <= cs_mode_d;
            done_q      <= done_d;
            cs_ok_q     <= cs_ok_d;
            cs_err_q    <= cs_err_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            td_q        <= td_d;
        end
    end

    assign td_o         = td_q;
    assign word_count_o = count_q;
    assign done_o       = done_q;
    assign cs_ok_o      = cs_ok_q;
    assign cs_err_o     = cs_err_q;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_pmu_stream_rx.sv
// Bench for pmu_stream_rx: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_pmu_stream_rx;

    localparam int W = 32;
    localparam int D = 4;

    logic        tck = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture = 1'b0, shift = 1'b0, update = 1'b0, td = 1'b0;
    logic        checksum_en = 1'b0, rdy = 1'b0;
    logic        td_o, word_valid_o, done_o, cs_ok_o, cs_err_o, frame_err_o, overflow_o;
    logic [W-1:0] word_o;
    logic [15:0]  word_count_o;

    pmu_stream_rx #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
        .tck_i(tck), .rst_ni(rst_n), .capture_i(capture), .shift_i(shift),
        .update_i(update), .td_i(td), .checksum_en_i(checksum_en), .td_o(td_o),
        .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(rdy),
        .word_count_o(word_count_o), .done_o(done_o), .cs_ok_o(cs_ok_o),
        .cs_err_o(cs_err_o), .frame_err_o(frame_err_o), .overflow_o(overflow_o)
    );

    always #5 tck = ~tck;

    int errors = 0;
    int checks = 0;

    // Reference model: frame state, assembled bits, queued words, status flags.
    int          m_state;         // 0 idle, 1 receiving, 2 closed
    bit          m_cs;
    int          m_acnt;
    logic [W-1:0] m_asm;
    bit          m_pv;
    logic [W-1:0] m_pend;
    bit          m_sv;
    logic [W-1:0] m_sd;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_sum;
    int          m_count;
    bit          m_done, m_ok, m_err, m_ferr, m_ovf;
    bit          m_hist[$];
    logic [W-1:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 32'hDEADBEEF;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cs = 0; m_acnt = 0; m_asm = '0; m_pv = 0; m_pend = '0;
        m_sv = 0; m_sd = '0; m_q.delete(); m_sum = '0; m_count = 0;
        m_done = 0; m_ok = 0; m_err = 0; m_ferr = 0; m_ovf = 0; m_hist.delete();
    endtask

    task automatic model_step(input bit cap, input bit sh, input bit upd, input bit t, input bit r);
        bit pop;
        pop = (m_q.size() > 0) && r;
        if (pop) void'(m_q.pop_front());
        if (m_sv) begin
            if (m_q.size() < D) begin
                m_q.push_back(m_sd);
                if (m_count < 65535) m_count++;
                m_sum = m_sum + m_sd;
            end else begin
                m_ovf = 1;
            end
        end
        m_sv = 0;
        if (cap) begin
            m_state = 1; m_acnt = 0; m_pv = 0; m_sum = '0; m_count = 0;
            m_cs = checksum_en; m_done = 0; m_ok = 0; m_err = 0; m_ferr = 0; m_ovf = 0;
        end else if (m_state == 1) begin
            if (upd) begin
                m_state = 2;
                m_done  = 1;
                m_ferr  = (m_acnt != 0);
                if (m_cs) begin
                    m_ok  = m_pv && (m_pend == W'(0) - m_sum);
                    m_err = !m_ok;
                end
                m_pv = 0;
            end else if (sh) begin
                m_hist.push_back(t);
                m_asm[m_acnt] = t;
                m_acnt++;
                if (m_acnt == W) begin
                    m_acnt = 0;
                    if (m_cs) begin
                        if (m_pv) begin m_sv = 1; m_sd = m_pend; end
                        m_pend = m_asm;
                        m_pv   = 1;
                    end else begin
                        m_sv = 1; m_sd = m_asm;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("valid", word_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) chk("word", word_o, m_q[0]);
        chk("count", word_count_o, m_count);
        chk("done", done_o, m_done);
        chk("cs_ok", cs_ok_o, m_ok);
        chk("cs_err", cs_err_o, m_err);
        chk("frame_err", frame_err_o, m_ferr);
        chk("overflow", overflow_o, m_ovf);
        chk("td_o", td_o, (m_hist.size() >= W) ? m_hist[m_hist.size() - W] : 1'b0);
    endtask

    task automatic step(input bit cap, input bit sh, input bit upd, input bit t, input bit r);
        capture = cap; shift = sh; update = upd; td = t; rdy = r;
        if (word_valid_o && r) got.push_back(word_o);
        model_step(cap, sh, upd, t, r);
        @(posedge tck);
        @(negedge tck);
        check_all();
    endtask

    function automatic bit rnd_rdy(input int rp);
        return $urandom_range(99) < rp;
    endfunction

    task automatic shift_bits(input logic [W-1:0] w, input int n, input int rp, input int gap);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap) step(0, 0, 0, $urandom_range(1), rnd_rdy(rp));
            step(0, 1, 0, w[i], rnd_rdy(rp));
        end
    endtask

    task automatic begin_frame(input bit ce, input int rp);
        checksum_en = ce;
        step(1, 0, 0, 0, rnd_rdy(rp));
    endtask

    task automatic end_frame(input int rp);
        step(0, 0, 0, 0, rnd_rdy(rp));
        step(0, 0, 1, 0, rnd_rdy(rp));
        step(0, 0, 0, 0, rnd_rdy(rp));
        step(0, 0, 0, 0, rnd_rdy(rp));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] data[$];
        logic [W-1:0] s;
        model_reset();
        #1;
        chk("rst_valid", word_valid_o, 0);
        chk("rst_count", word_count_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_td", td_o, 0);
        @(negedge tck);
        rst_n = 1'b1;
        check_all();

        // 64 ones, no checksum
        got.delete();
        begin_frame(0, 100);
        shift_bits(32'hFFFFFFFF, W, 100, 0);
        shift_bits(32'hFFFFFFFF, W, 100, 0);
        end_frame(100);
        drain(3);
        chk("wo_cs_n", got.size(), 2);
        chk("wo_cs_w0", got_at(0), 32'hFFFFFFFF);
        chk("wo_cs_w1", got_at(1), 32'hFFFFFFFF);
        chk("wo_cs_count", word_count_o, 2);
        chk("wo_cs_done", done_o, 1);
        chk("wo_cs_errs", {cs_ok_o, cs_err_o, frame_err_o, overflow_o}, 0);

        // checksum frames: good then bad
        for (int k = 0; k < 2; k++) begin
            got.delete();
            begin_frame(1, 100);
            shift_bits(32'd1, W, 100, 0);
            shift_bits(32'd2, W, 100, 0);
            shift_bits((k == 0) ? 32'hFFFFFFFD : 32'h0, W, 100, 0);
            end_frame(100);
            drain(3);
            chk("cs_n", got.size(), 2);
            chk("cs_w0", got_at(0), 32'd1);
            chk("cs_w1", got_at(1), 32'd2);
            chk("cs_ok_lit", cs_ok_o, (k == 0));
            chk("cs_err_lit", cs_err_o, (k == 1));
            chk("cs_count", word_count_o, 2);
        end

        // 40 bits: one word plus a partial
        got.delete();
        begin_frame(0, 100);
        shift_bits(32'hA5A50F0F, W, 100, 0);
        shift_bits(32'h000000C3, 8, 100, 0);
        end_frame(100);
        drain(2);
        chk("part_n", got.size(), 1);
        chk("part_w0", got_at(0), 32'hA5A50F0F);
        chk("part_ferr", frame_err_o, 1);
        chk("part_count", word_count_o, 1);

        // ready low, 6 words into a 4-deep FIFO
        got.delete();
        begin_frame(0, 0);
        for (int i = 0; i < 6; i++) shift_bits(32'h10 + i, W, 0, 0);
        end_frame(0);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_count", word_count_o, 4);
        chk("ovf_head", word_o, 32'h10);
        drain(6);
        chk("ovf_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("ovf_word", got_at(i), 32'h10 + i);

        // asynchronous reset mid-shift with a word held in the FIFO
        begin_frame(0, 0);
        shift_bits(32'h12345678, W, 0, 0);
        shift_bits(32'hFFFFFFFF, 20, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", word_valid_o, 0);
        chk("arst_word", word_o, 0);
        chk("arst_count", word_count_o, 0);
        chk("arst_td", td_o, 0);
        chk("arst_flags", {done_o, cs_ok_o, cs_err_o, frame_err_o, overflow_o}, 0);
        capture = 0; shift = 0; update = 0; td = 0; rdy = 0;
        model_reset();
        @(negedge tck);
        rst_n = 1'b1;
        check_all();
        // idle ignores shift and update
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1);
        chk("idle_done", done_o, 0);
        chk("idle_valid", word_valid_o, 0);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            bit ce;
            int nw, rp, part;
            ce = 1'($urandom_range(1));
            nw = $urandom_range(5);
            case ($urandom_range(2))
                0: rp = 100;
                1: rp = 70;
                default: rp = 20;
            endcase
            part = ($urandom_range(3) == 0) ? $urandom_range(1, W - 1) : 0;
            data.delete();
            s = '0;
            for (int i = 0; i < nw; i++) begin
                data.push_back($urandom);
                s = s + data[i];
            end
            begin_frame(ce, rp);
            for (int i = 0; i < nw; i++) shift_bits(data[i], W, rp, 10);
            if (ce && nw > 0 && $urandom_range(1) == 1) shift_bits(W'(0) - s, W, rp, 10);
            else if (ce) shift_bits($urandom, W, rp, 10);
            if (part > 0) shift_bits($urandom, part, rp, 10);
            end_frame(rp);
            for (int i = 0; i < $urandom_range(5, 2); i++)
                step(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), rnd_rdy(rp));
        end
        drain(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
